loop_group_scheduler: RTL and testbench

Time-slicing scheduler that sits in front of the grouped loop-iteration FSM (controller_fsm_group) and shares it among up to NUM_MAX_GROUPS loop groups. It snoops loop-config writes to learn which groups are armed, launches the FSM on a block start, and rotates `loop_group_id` round-robin on quantum expiry. The FSM saves and restores per-group iteration state whenever `loop_group_id` changes. When every armed group has reported completion, the scheduler issues `block_done`, which clears both its own state and the FSM's loop config.

---
 rtl/loop_group_scheduler.sv | 119 +++++++++++
 tb/tb_loop_group_scheduler.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/loop_group_scheduler.sv
// Round-robin time-slicing scheduler sharing one grouped loop FSM among up to NUM_MAX_GROUPS
// armed loop groups; launches on block start, preempts on quantum expiry, reports block completion.
module loop_group_scheduler #(
  parameter int GROUP_ID_W     = 2,
  parameter int NUM_MAX_GROUPS = 1 << GROUP_ID_W,
  parameter int QUANTUM_W      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stall,
  input  logic                  cfg_loop_iter_v,
  input  logic [GROUP_ID_W-1:0] cfg_loop_group_id,
  input  logic                  cfg_quantum_v,
  input  logic [QUANTUM_W-1:0]  cfg_quantum,
  input  logic                  fsm_done,
  output logic [GROUP_ID_W-1:0] loop_group_id,
  output logic                  fsm_start,
  output logic                  block_done,
  output logic                  busy,
  output logic [7:0]            switch_count
);

  typedef enum logic [2:0] {IDLE, LAUNCH, RUN, SWITCH, FINISH} state_t;

  state_t                    state, state_nx;
  logic                      start_d;
  logic [NUM_MAX_GROUPS-1:0] armed, pending, active_mask, others;
  logic [GROUP_ID_W-1:0]     active, lowest_armed, next_active;
  logic [QUANTUM_W-1:0]      qcnt, quantum;
  logic                      start_rise, expire;

  assign start_rise  = start & ~start_d;
  assign active_mask = {{(NUM_MAX_GROUPS-1){1'b0}}, 1'b1} << active;
  assign others      = pending & ~active_mask;
  assign expire      = (quantum != '0) && !stall && (qcnt == QUANTUM_W'(1));

  always_comb begin
    lowest_armed = '0;
    for (int i = NUM_MAX_GROUPS - 1; i >= 0; i--)
      if (armed[i]) lowest_armed = GROUP_ID_W'(i);
  end

  // Search downward so the nearest pending group after active (wrapping) wins.
  always_comb begin
    next_active = active;
    for (int k = NUM_MAX_GROUPS - 1; k >= 1; k--) begin
      if (pending[(int'(active) + k) % NUM_MAX_GROUPS])
        next_active = GROUP_ID_W'((int'(active) + k) % NUM_MAX_GROUPS);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_rise) state_nx = (armed == '0) ? FINISH : LAUNCH;
      LAUNCH:  state_nx = RUN;
      RUN: begin
        if (fsm_done)                     state_nx = (others != '0) ? SWITCH : FINISH;
        else if (expire && others != '0)  state_nx = SWITCH;
      end
      SWITCH:  state_nx = RUN;
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      start_d      <= 1'b0;
      armed        <= '0;
      pending      <= '0;
      active       <= '0;
      qcnt         <= '0;
      quantum      <= '0;
      switch_count <= '0;
    end else begin
      start_d <= start;
      if (cfg_quantum_v) quantum <= cfg_quantum;
      // Block completion clears the armed set even against a concurrent config write.
      if (state == FINISH)      armed <= '0;
      else if (cfg_loop_iter_v) armed[cfg_loop_group_id] <= 1'b1;
      case (state)
        IDLE: begin
          if (start_rise && armed != '0) begin
            pending      <= armed;
            active       <= lowest_armed;
            switch_count <= '0;
          end
        end
        LAUNCH: qcnt <= quantum;
        RUN: begin
          if (fsm_done)                          pending[active] <= 1'b0;
          else if (expire) begin
            if (others == '0)                    qcnt <= quantum;
          end else if (!stall && quantum != '0)  qcnt <= qcnt - QUANTUM_W'(1);
        end
        SWITCH: begin
          active <= next_active;
          qcnt   <= quantum;
          if (switch_count != 8'hFF) switch_count <= switch_count + 8'd1;
        end
        FINISH: pending <= '0;
        default: ;
      endcase
    end
  end

  assign loop_group_id = active;
  assign fsm_start     = (state == LAUNCH);
  assign block_done    = (state == FINISH);
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_loop_group_scheduler.sv
// Directed bench for loop_group_scheduler: a per-cycle vector table for a two-group
// cooperative block plus hand-written preemption, stall, empty-block and reset sequences.
module tb_loop_group_scheduler;
  logic       clk = 1'b0;
  logic       reset;
  logic       start, stall, cfg_loop_iter_v, cfg_quantum_v, fsm_done;
  logic [1:0] cfg_loop_group_id;
  logic [7:0] cfg_quantum;
  logic [1:0] loop_group_id;
  logic       fsm_start, block_done, busy;
  logic [7:0] switch_count;

  int errors = 0;
  int checks = 0;

  loop_group_scheduler dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .cfg_loop_iter_v(cfg_loop_iter_v), .cfg_loop_group_id(cfg_loop_group_id),
    .cfg_quantum_v(cfg_quantum_v), .cfg_quantum(cfg_quantum), .fsm_done(fsm_done),
    .loop_group_id(loop_group_id), .fsm_start(fsm_start), .block_done(block_done),
    .busy(busy), .switch_count(switch_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic start, stall, done;
    int   id;
    logic fs, bd, bz;
    int   sw;
  } vec_t;

  vec_t tbl[17];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int id, input int fs, input int bd,
                         input int bz, input int sw);
    chk({tag, " id"}, int'(loop_group_id), id);
    chk({tag, " fsm_start"}, int'(fsm_start), fs);
    chk({tag, " block_done"}, int'(block_done), bd);
    chk({tag, " busy"}, int'(busy), bz);
    chk({tag, " switch_count"}, int'(switch_count), sw);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    start = 0; stall = 0; fsm_done = 0;
    cfg_loop_iter_v = 0; cfg_loop_group_id = 0; cfg_quantum_v = 0; cfg_quantum = 0;
    repeat (2) cyc();
    reset = 1'b1;
    cyc();
  endtask

  task automatic cfg_group(input int g);
    cfg_loop_iter_v = 1; cfg_loop_group_id = 2'(g);
    cyc();
    cfg_loop_iter_v = 0;
  endtask

  task automatic set_q(input int q);
    cfg_quantum_v = 1; cfg_quantum = 8'(q);
    cyc();
    cfg_quantum_v = 0;
  endtask

  initial begin
    int first_switch;

    // Groups {0,2}, no preemption; row = inputs for one edge, then state after it.
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b1, 0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 0};
    for (int i = 2; i <= 9; i++) tbl[i] = '{1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 0};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b1, 0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b1, 1};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b1, 1};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b1, 1};
    tbl[14] = '{1'b0, 1'b0, 1'b1, 2, 1'b0, 1'b1, 1'b1, 1};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1};
    tbl[16] = '{1'b0, 1'b0, 1'b1, 2, 1'b0, 1'b0, 1'b0, 1};

    do_reset();
    chk_all("reset", 0, 0, 0, 0, 0);

    cfg_group(0);
    cfg_group(2);
    set_q(0);
    for (int i = 0; i < 17; i++) begin
      start = tbl[i].start; stall = tbl[i].stall; fsm_done = tbl[i].done;
      cyc();
      chk_all($sformatf("coop row%0d", i), tbl[i].id, int'(tbl[i].fs), int'(tbl[i].bd),
              int'(tbl[i].bz), tbl[i].sw);
    end
    start = 0; fsm_done = 0;

    // Four groups, quantum 4: each group shown 5 cycles after the launch slice.
    do_reset();
    for (int g = 0; g < 4; g++) cfg_group(g);
    set_q(4);
    start = 1; cyc(); start = 0;
    chk_all("rr launch", 0, 1, 0, 1, 0);
    for (int t = 1; t <= 40; t++) begin
      cyc();
      chk($sformatf("rr t%0d id", t), int'(loop_group_id), ((t - 1) / 5) % 4);
      chk($sformatf("rr t%0d sw", t), int'(switch_count), (t - 1) / 5);
    end

    // Single group 1, quantum 3: reloads forever without switching.
    do_reset();
    cfg_group(1);
    set_q(3);
    start = 1; cyc(); start = 0;
    chk_all("single launch", 1, 1, 0, 1, 0);
    for (int t = 1; t <= 12; t++) begin
      cyc();
      chk_all($sformatf("single t%0d", t), 1, 0, 0, 1, 0);
    end
    fsm_done = 1; cyc(); fsm_done = 0;
    chk_all("single finish", 1, 0, 1, 1, 0);
    cyc();
    chk_all("single idle", 1, 0, 0, 0, 0);

    // Stall for 6 edges mid-slice pushes the switch from t6 to t12.
    do_reset();
    cfg_group(0);
    cfg_group(1);
    set_q(4);
    start = 1; cyc(); start = 0;
    first_switch = -1;
    for (int t = 1; t <= 50; t++) begin
      stall = (t >= 2 && t <= 7);
      cyc();
      if (first_switch < 0 && loop_group_id == 2'd1) first_switch = t;
    end
    stall = 0;
    chk("stall switch cycle", first_switch, 12);

    // Empty block: straight to FINISH; config write during FINISH is discarded.
    do_reset();
    start = 1; cyc();
    chk_all("empty finish", 0, 0, 1, 1, 0);
    start = 0; cfg_loop_iter_v = 1; cfg_loop_group_id = 2'd3;
    cyc();
    cfg_loop_iter_v = 0;
    chk_all("empty idle", 0, 0, 0, 0, 0);
    start = 1; cyc(); start = 0;
    chk_all("clear wins", 0, 0, 1, 1, 0);
    cyc();
    chk_all("clear wins idle", 0, 0, 0, 0, 0);

    // Completion coincident with expiry on group 0 of {0,1}: group 0 never returns.
    do_reset();
    cfg_group(0);
    cfg_group(1);
    set_q(4);
    start = 1; cyc(); start = 0;
    repeat (4) cyc();
    fsm_done = 1; cyc(); fsm_done = 0;
    chk_all("coinc switch", 0, 0, 0, 1, 0);
    cyc();
    chk_all("coinc run1", 1, 0, 0, 1, 1);
    for (int t = 0; t < 20; t++) begin
      cyc();
      chk($sformatf("coinc hold%0d id", t), int'(loop_group_id), 1);
      chk($sformatf("coinc hold%0d sw", t), int'(switch_count), 1);
    end

    reset = 0;
    #1;
    chk_all("async reset", 0, 0, 0, 0, 0);
    #3;
    reset = 1;
    for (int t = 0; t < 5; t++) begin
      cyc();
      chk_all($sformatf("post reset%0d", t), 0, 0, 0, 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
